// File: rtl/transposer_arbiter.sv
// ---------------------------------------------------------------------------
// transposer_arbiter
//
// Purpose:
//   Shares one matrix_transposer between two requesters, one whole matrix
//   (BEATS rows) at a time. Grants are round-robin and beats of different
//   matrices are never interleaved. The owner of every granted matrix is
//   queued in a small tag FIFO so that the transposed rows coming back
//   from the transposer are steered to the right output port.
//
// Parameters:
//   DATA_W    - row width in bits
//   BEATS     - rows per matrix
//   TAG_DEPTH - matrices granted but not yet fully returned
//
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   r0_*/r1_*                - requester row streams (data/valid/ready)
//   m_data/m_valid/m_ready   - row stream into the transposer
//   m2f_data/m2f_valid       - transposed rows from the transposer
//   f2m_ready                - arbiter accepts a transposed row
//   o0_*/o1_*                - transposed rows to each owner
//   stat0/stat1              - completed-grant counters (optional)
//
// Configuration:
//   TRANSPOSER_ARB_STATS_EN  - when defined, adds the stat0/stat1 saturating
//                              16-bit grant counters and their ports.
// ---------------------------------------------------------------------------
module transposer_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BEATS     = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] r0_data,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r1_data,
    input  logic              r1_valid,
    output logic              r1_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m2f_data,
    input  logic              m2f_valid,
    output logic              f2m_ready,
    output logic [DATA_W-1:0] o0_data,
    output logic              o0_valid,
    input  logic              o0_ready,
    output logic [DATA_W-1:0] o1_data,
    output logic              o1_valid,
    input  logic              o1_ready
`ifdef TRANSPOSER_ARB_STATS_EN
    ,
    output logic [15:0]       stat0,
    output logic [15:0]       stat1
`endif
);

    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int FCNT_W = $clog2(TAG_DEPTH + 1);

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(TAG_DEPTH - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(TAG_DEPTH);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]  inCnt_q, inCnt_d;
    logic [CNT_W-1:0]  outCnt_q, outCnt_d;

    logic              tagMem_q [TAG_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
    logic [FCNT_W-1:0] tagCnt_q;

    logic              tagPush, tagPop, tagFull, tagEmpty, tagHead;
    logic              mValid, r0Ready, r1Ready;
    logic              f2mReady, o0Valid, o1Valid;

    assign tagFull  = (tagCnt_q == FULL_CNT);
    assign tagEmpty = (tagCnt_q == '0);
    assign tagHead  = tagMem_q[rdPtr_q];

    // Input side: pick an owner in IDLE, then pass that owner's beats
    // straight through to the transposer until the last beat is accepted.
    // A full tag FIFO only holds off new grants; a matrix already in
    // BUSY always runs to completion.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        inCnt_d = inCnt_q;
        tagPush = 1'b0;
        mValid  = 1'b0;
        r0Ready = 1'b0;
        r1Ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((r0_valid || r1_valid) && !tagFull) begin
                    state_d = BUSY;
                    // Only when both ask does the round-robin pointer matter.
                    owner_d = (r0_valid && r1_valid) ? rrPtr_q : r1_valid;
                end
            end
            BUSY: begin
                mValid = owner_q ? r1_valid : r0_valid;
                if (owner_q) begin
                    r1Ready = m_ready;
                end else begin
                    r0Ready = m_ready;
                end
                if (mValid && m_ready) begin
                    if (inCnt_q == LAST_BEAT) begin
                        tagPush = 1'b1;
                        rrPtr_d = ~owner_q;
                        inCnt_d = '0;
                        state_d = IDLE;
                    end else begin
                        inCnt_d = inCnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_data = owner_q ? r1_data : r0_data;

    // Return side: the tag at the FIFO head names the owner of the rows
    // currently leaving the transposer. With no tag the row is simply not
    // accepted, so the transposer keeps holding it.
    always_comb begin
        f2mReady = 1'b0;
        o0Valid  = 1'b0;
        o1Valid  = 1'b0;
        outCnt_d = outCnt_q;
        tagPop   = 1'b0;
        if (!tagEmpty) begin
            if (tagHead) begin
                o1Valid  = m2f_valid;
                f2mReady = o1_ready;
            end else begin
                o0Valid  = m2f_valid;
                f2mReady = o0_ready;
            end
            if (m2f_valid && f2mReady) begin
                if (outCnt_q == LAST_BEAT) begin
                    outCnt_d = '0;
                    tagPop   = 1'b1;
                end else begin
                    outCnt_d = outCnt_q + 1'b1;
                end
            end
        end
    end

    assign o0_data = m2f_data;
    assign o1_data = m2f_data;

    // Handshake outputs are forced low for the whole time reset is high,
    // independent of the inputs, so neighbours see a quiet interface.
    assign m_valid   = mValid   && !rst;
    assign r0_ready  = r0Ready  && !rst;
    assign r1_ready  = r1Ready  && !rst;
    assign f2m_ready = f2mReady && !rst;
    assign o0_valid  = o0Valid  && !rst;
    assign o1_valid  = o1Valid  && !rst;

    // Control state: FSM, owner, round-robin pointer and both beat counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rrPtr_q  <= 1'b0;
            inCnt_q  <= '0;
            outCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rrPtr_q  <= rrPtr_d;
            inCnt_q  <= inCnt_d;
            outCnt_q <= outCnt_d;
        end
    end

    // Tag FIFO of owner IDs. A simultaneous push and pop leaves the count
    // unchanged while both pointers move on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tagMem_q[i] <= 1'b0;
            end
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            tagCnt_q <= '0;
        end else begin
            if (tagPush) begin
                tagMem_q[wrPtr_q] <= owner_q;
                wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
            end
            if (tagPop) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
            end
            case ({tagPush, tagPop})
                2'b10:   tagCnt_q <= tagCnt_q + 1'b1;
                2'b01:   tagCnt_q <= tagCnt_q - 1'b1;
                default: tagCnt_q <= tagCnt_q;
            endcase
        end
    end

`ifdef TRANSPOSER_ARB_STATS_EN
    logic [15:0] stat0_q, stat1_q;

    // Completed-grant counters, bumped on each requester's last input beat
    // and saturating rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (tagPush) begin
            if (!owner_q && stat0_q != 16'hFFFF) begin
                stat0_q <= stat0_q + 16'd1;
            end
            if (owner_q && stat1_q != 16'hFFFF) begin
                stat1_q <= stat1_q + 16'd1;
            end
        end
    end

    assign stat0 = stat0_q;
    assign stat1 = stat1_q;
`else
    // Statistics disabled: no counters and no stat ports.
`endif

endmodule

// File: tb/tb_transposer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_transposer_arbiter
//
// Directed bench for transposer_arbiter. A small behavioural transposer
// sits on the m_* / m2f_* side; requester traffic and output backpressure
// are driven from one initial block through per-scenario tasks.
// ---------------------------------------------------------------------------
module tb_transposer_arbiter;

    localparam int DATA_W    = 32;
    localparam int BEATS     = 4;
    localparam int TAG_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] r0_data = '0, r1_data = '0;
    logic              r0_valid = 1'b0, r1_valid = 1'b0;
    logic              r0_ready, r1_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [DATA_W-1:0] m2f_data;
    logic              m2f_valid;
    logic              f2m_ready;
    logic [DATA_W-1:0] o0_data, o1_data;
    logic              o0_valid, o1_valid;
    logic              o0_ready = 1'b1, o1_ready = 1'b1;
`ifdef TRANSPOSER_ARB_STATS_EN
    logic [15:0]       stat0, stat1;
`endif

    int nChecks = 0;
    int nFails  = 0;

    transposer_arbiter #(
        .DATA_W   (DATA_W),
        .BEATS    (BEATS),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r0_data  (r0_data),
        .r0_valid (r0_valid),
        .r0_ready (r0_ready),
        .r1_data  (r1_data),
        .r1_valid (r1_valid),
        .r1_ready (r1_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m2f_data (m2f_data),
        .m2f_valid(m2f_valid),
        .f2m_ready(f2m_ready),
        .o0_data  (o0_data),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o1_data  (o1_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready)
`ifdef TRANSPOSER_ARB_STATS_EN
        ,
        .stat0    (stat0),
        .stat1    (stat1)
`endif
    );

    always #5 clk = ~clk;

    // Row i of matrix mat from requester req: byte j = 16*i + j + 4*mat + 128*req.
    // For req 0, mat 0 this gives 32'h03020100, 13121110, 23222120, 33323130.
    function automatic logic [31:0] rowWord(input int req, input int mat, input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            w[8*j +: 8] = 8'(16*i + j + 4*mat + 128*req);
        end
        return w;
    endfunction

    // Transposed row j: byte i of the result is byte j of input row i.
    function automatic logic [31:0] trRow(input int req, input int mat, input int j);
        logic [31:0] w, r;
        for (int i = 0; i < 4; i++) begin
            r = rowWord(req, mat, i);
            w[8*i +: 8] = r[8*j +: 8];
        end
        return w;
    endfunction

    // Behavioural transposer: always ready on its output queue side, emits
    // the four transposed rows once the fourth input row is taken.
    logic [31:0] inRows[$];
    logic [31:0] outRows[$];
    logic        tHeadValid = 1'b0;
    logic [31:0] tHead = '0;

    always @(posedge clk or posedge rst) begin
        logic [31:0] tw, rr;
        if (rst) begin
            inRows.delete();
            outRows.delete();
            tHeadValid <= 1'b0;
            tHead      <= '0;
        end else begin
            if (m2f_valid && f2m_ready) void'(outRows.pop_front());
            if (m_valid && m_ready) begin
                inRows.push_back(m_data);
                if (inRows.size() == BEATS) begin
                    for (int j = 0; j < 4; j++) begin
                        tw = '0;
                        for (int i = 0; i < 4; i++) begin
                            rr = inRows[i];
                            tw[8*i +: 8] = rr[8*j +: 8];
                        end
                        outRows.push_back(tw);
                    end
                    inRows.delete();
                end
            end
            tHeadValid <= (outRows.size() != 0);
            tHead      <= (outRows.size() != 0) ? outRows[0] : '0;
        end
    end

    assign m2f_valid = tHeadValid;
    assign m2f_data  = tHead;

    // Monitor: logs every handshake on the falling edge.
    int          cyc = 0;
    logic [31:0] mLog[$];
    bit          mOwn[$];
    int          mCyc[$];
    logic [31:0] o0Log[$];
    logic [31:0] o1Log[$];
    bit          outOrder[$];
    int          o1ValidCycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                mLog.push_back(m_data);
                mOwn.push_back(r1_ready);
                mCyc.push_back(cyc);
            end
            if (o0_valid && o0_ready) begin
                o0Log.push_back(o0_data);
                outOrder.push_back(1'b0);
            end
            if (o1_valid && o1_ready) begin
                o1Log.push_back(o1_data);
                outOrder.push_back(1'b1);
            end
            if (o1_valid) o1ValidCycles <= o1ValidCycles + 1;
        end
    end

    // Per-run observations gathered by runTraffic.
    int bothReadyViol, stallReadyViol, stallSeen, rdy1Cycles;
    int holdViol, holdValid1, firstValidCyc, holdBeats;

    // Streams nMat0/nMat1 matrices from each requester (valid held while
    // rows remain), stalls m_ready for stallLen cycles once stallBeat beats
    // have passed, and holds o0/o1 ready low for the first o0Hold/o1Hold
    // cycles. Called at posedge+1, returns at posedge+1.
    task automatic runTraffic(input int nMat0, input int nMat1, input int stallBeat,
                              input int stallLen, input int o0Hold, input int o1Hold,
                              output int tmo);
        int idx0 = 0, idx1 = 0, beats = 0, stallLeft = stallLen, cycN = 0;
        int o0Start = o0Log.size(), o1Start = o1Log.size();
        bit f0, f1, mf, firstSeen = 0;
        tmo = 0;
        bothReadyViol = 0; stallReadyViol = 0; stallSeen = 0; rdy1Cycles = 0;
        holdViol = 0; holdValid1 = 0; firstValidCyc = -1; holdBeats = -1;
        forever begin
            r0_valid = (idx0 < nMat0*BEATS);
            r0_data  = r0_valid ? rowWord(0, idx0/BEATS, idx0%BEATS) : '0;
            r1_valid = (idx1 < nMat1*BEATS);
            r1_data  = r1_valid ? rowWord(1, idx1/BEATS, idx1%BEATS) : '0;
            m_ready  = !(beats == stallBeat && stallLeft > 0);
            o0_ready = (cycN >= o0Hold);
            o1_ready = (cycN >= o1Hold);
            @(negedge clk);
            f0 = r0_valid && r0_ready;
            f1 = r1_valid && r1_ready;
            mf = m_valid && m_ready;
            if (r0_ready && r1_ready) bothReadyViol++;
            if (!m_ready && (r0_ready || r1_ready)) stallReadyViol++;
            if (!m_ready && m_valid) stallSeen++;
            if (r1_ready) rdy1Cycles++;
            if (!o1_ready && o1_valid) begin
                holdValid1++;
                if (f2m_ready) holdViol++;
            end
            if (!o0_ready && o0_valid && f2m_ready) holdViol++;
            if (!firstSeen && (r0_valid || r1_valid)) begin
                firstSeen = 1;
                firstValidCyc = cyc;
            end
            @(posedge clk);
            #1;
            if (f0) idx0++;
            if (f1) idx1++;
            if (mf) beats++;
            if (!m_ready) stallLeft--;
            cycN++;
            if (cycN == o0Hold) holdBeats = beats;
            if (idx0 == nMat0*BEATS && idx1 == nMat1*BEATS &&
                o0Log.size() - o0Start == nMat0*BEATS &&
                o1Log.size() - o1Start == nMat1*BEATS) break;
            if (cycN >= 400) begin
                tmo = 1;
                break;
            end
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        m_ready  = 1'b1;
        o0_ready = 1'b1;
        o1_ready = 1'b1;
    endtask

    task automatic test_reset();
        r0_valid = 1'b1; r0_data = rowWord(0, 0, 0);
        r1_valid = 1'b1; r1_data = rowWord(1, 0, 0);
        m_ready = 1'b1; o0_ready = 1'b1; o1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if ({m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid} !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %b, need 000000",
                     {m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid});
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        nChecks++;
        if ({m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid} !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL idle_after_reset: got %b, need 000000",
                     {m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid});
        end
    endtask

    task automatic test_simultaneous();
        int s = mLog.size(), a = o0Log.size(), b = o1Log.size(), os = outOrder.size(), tmo;
        runTraffic(1, 1, -1, 0, 0, 0, tmo);
        nChecks++;
        if (tmo !== 0 || mLog.size() - s !== 8) begin
            nFails++;
            $display("[TB] FAIL sim_done: timeout %0d beats %0d, need 0 and 8", tmo, mLog.size() - s);
        end
        for (int k = 0; k < 8; k++) begin
            nChecks++;
            if (mOwn[s+k] !== 1'(k >= 4) || mLog[s+k] !== rowWord(k/4, 0, k%4)) begin
                nFails++;
                $display("[TB] FAIL sim_beat%0d: owner %0d data %h, need %0d %h",
                         k, mOwn[s+k], mLog[s+k], k/4, rowWord(k/4, 0, k%4));
            end
            nChecks++;
            if (outOrder[os+k] !== 1'(k >= 4)) begin
                nFails++;
                $display("[TB] FAIL sim_out_order%0d: port %0d, need %0d", k, outOrder[os+k], k/4);
            end
        end
        nChecks++;
        if (rdy1Cycles !== 4 || bothReadyViol !== 0) begin
            nFails++;
            $display("[TB] FAIL sim_r1_ready: r1_ready cycles %0d both %0d, need 4 and 0",
                     rdy1Cycles, bothReadyViol);
        end
        for (int j = 0; j < 4; j++) begin
            nChecks++;
            if (o0Log[a+j] !== trRow(0, 0, j) || o1Log[b+j] !== trRow(1, 0, j)) begin
                nFails++;
                $display("[TB] FAIL sim_out_row%0d: o0 %h o1 %h, need %h %h",
                         j, o0Log[a+j], o1Log[b+j], trRow(0, 0, j), trRow(1, 0, j));
            end
        end
    endtask

    task automatic test_fairness();
        int s = mLog.size(), a = o0Log.size(), b = o1Log.size(), tmo;
        runTraffic(4, 4, -1, 0, 0, 0, tmo);
        nChecks++;
        if (tmo !== 0 || mLog.size() - s !== 32) begin
            nFails++;
            $display("[TB] FAIL fair_done: timeout %0d beats %0d, need 0 and 32", tmo, mLog.size() - s);
        end
        for (int g = 0; g < 8; g++) begin
            nChecks++;
            if (mOwn[s+4*g] !== 1'(g % 2) || mLog[s+4*g+3] !== rowWord(g % 2, g/2, 3)) begin
                nFails++;
                $display("[TB] FAIL fair_grant%0d: owner %0d last row %h, need %0d %h",
                         g, mOwn[s+4*g], mLog[s+4*g+3], g % 2, rowWord(g % 2, g/2, 3));
            end
        end
        nChecks++;
        if (mCyc[s+31] - mCyc[s] !== 38) begin
            nFails++;
            $display("[TB] FAIL fair_throughput: span %0d cycles, need 38", mCyc[s+31] - mCyc[s]);
        end
        nChecks++;
        if (o0Log[a+15] !== trRow(0, 3, 3) || o1Log[b+15] !== trRow(1, 3, 3)) begin
            nFails++;
            $display("[TB] FAIL fair_last_rows: o0 %h o1 %h, need %h %h",
                     o0Log[a+15], o1Log[b+15], trRow(0, 3, 3), trRow(1, 3, 3));
        end
    endtask

    task automatic test_r0_only();
        logic [31:0] inExp[4], outExp[4];
        int s = mLog.size(), a = o0Log.size(), o1v = o1ValidCycles, tmo;
        inExp  = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
        outExp = '{32'h30201000, 32'h31211101, 32'h32221202, 32'h33231303};
        runTraffic(1, 0, -1, 0, 0, 0, tmo);
        nChecks++;
        if (tmo !== 0) begin
            nFails++;
            $display("[TB] FAIL r0_timeout: timeout %0d, need 0", tmo);
        end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (mLog[s+k] !== inExp[k] || o0Log[a+k] !== outExp[k]) begin
                nFails++;
                $display("[TB] FAIL r0_row%0d: m %h o0 %h, need %h %h",
                         k, mLog[s+k], o0Log[a+k], inExp[k], outExp[k]);
            end
        end
        nChecks++;
        if (mCyc[s] - firstValidCyc !== 1 || mCyc[s+3] - mCyc[s] !== 3) begin
            nFails++;
            $display("[TB] FAIL r0_latency: first %0d span %0d, need 1 and 3",
                     mCyc[s] - firstValidCyc, mCyc[s+3] - mCyc[s]);
        end
        nChecks++;
        if (o1ValidCycles - o1v !== 0) begin
            nFails++;
            $display("[TB] FAIL r0_o1_quiet: o1_valid cycles %0d, need 0", o1ValidCycles - o1v);
        end
    endtask

    task automatic test_input_stall();
        int s = mLog.size(), a = o0Log.size(), tmo;
        runTraffic(1, 0, 2, 3, 0, 0, tmo);
        nChecks++;
        if (tmo !== 0 || mLog.size() - s !== 4) begin
            nFails++;
            $display("[TB] FAIL stall_done: timeout %0d beats %0d, need 0 and 4", tmo, mLog.size() - s);
        end
        nChecks++;
        if (stallSeen !== 3 || stallReadyViol !== 0) begin
            nFails++;
            $display("[TB] FAIL stall_ready: stalled %0d ready-in-stall %0d, need 3 and 0",
                     stallSeen, stallReadyViol);
        end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (mLog[s+k] !== rowWord(0, 0, k) || o0Log[a+k] !== trRow(0, 0, k)) begin
                nFails++;
                $display("[TB] FAIL stall_row%0d: m %h o0 %h, need %h %h",
                         k, mLog[s+k], o0Log[a+k], rowWord(0, 0, k), trRow(0, 0, k));
            end
        end
    endtask

    task automatic test_output_backpressure();
        int b = o1Log.size(), tmo;
        runTraffic(0, 1, -1, 0, 0, 14, tmo);
        nChecks++;
        if (tmo !== 0) begin
            nFails++;
            $display("[TB] FAIL bp_timeout: timeout %0d, need 0", tmo);
        end
        nChecks++;
        if (holdValid1 !== 9 || holdViol !== 0) begin
            nFails++;
            $display("[TB] FAIL bp_hold: o1_valid held %0d f2m_ready leaks %0d, need 9 and 0",
                     holdValid1, holdViol);
        end
        for (int j = 0; j < 4; j++) begin
            nChecks++;
            if (o1Log[b+j] !== trRow(1, 0, j)) begin
                nFails++;
                $display("[TB] FAIL bp_row%0d: o1 %h, need %h", j, o1Log[b+j], trRow(1, 0, j));
            end
        end
        nChecks++;
        if ({f2m_ready, o0_valid, o1_valid} !== 3'b0) begin
            nFails++;
            $display("[TB] FAIL bp_tag_popped: got %b, need 000", {f2m_ready, o0_valid, o1_valid});
        end
    endtask

    task automatic test_tag_full();
        int a = o0Log.size(), tmo;
        runTraffic(5, 0, -1, 0, 40, 0, tmo);
        nChecks++;
        if (tmo !== 0) begin
            nFails++;
            $display("[TB] FAIL full_timeout: timeout %0d, need 0", tmo);
        end
        nChecks++;
        if (holdBeats !== 16) begin
            nFails++;
            $display("[TB] FAIL full_blocks_grant: beats while held %0d, need 16", holdBeats);
        end
        nChecks++;
        if (o0Log[a+16] !== trRow(0, 4, 0) || o0Log[a+19] !== trRow(0, 4, 3)) begin
            nFails++;
            $display("[TB] FAIL full_fifth: rows %h %h, need %h %h",
                     o0Log[a+16], o0Log[a+19], trRow(0, 4, 0), trRow(0, 4, 3));
        end
    endtask

    task automatic test_reset_mid();
        int cnt = 0, guard = 0, s, a, b, tmo;
        r1_valid = 1'b1;
        r1_data  = rowWord(1, 0, 0);
        m_ready  = 1'b1;
        while (cnt < 2 && guard < 20) begin
            @(negedge clk);
            if (r1_valid && r1_ready) cnt++;
            @(posedge clk);
            #1;
            guard++;
            r1_data = rowWord(1, 0, cnt);
        end
        nChecks++;
        if (cnt !== 2) begin
            nFails++;
            $display("[TB] FAIL rstmid_beats: r1 beats %0d, need 2", cnt);
        end
        r0_valid = 1'b1;
        r0_data  = rowWord(0, 0, 0);
        rst = 1'b1;
        #1;
        nChecks++;
        if ({m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid} !== 6'b0) begin
            nFails++;
            $display("[TB] FAIL rstmid_outputs: got %b, need 000000",
                     {m_valid, r0_ready, r1_ready, f2m_ready, o0_valid, o1_valid});
        end
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        s = mLog.size(); a = o0Log.size(); b = o1Log.size();
        runTraffic(1, 1, -1, 0, 0, 0, tmo);
        nChecks++;
        if (tmo !== 0 || mOwn[s] !== 1'b0 || mOwn[s+4] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL rstmid_regrant: timeout %0d owners %0d,%0d, need 0 and 0,1",
                     tmo, mOwn[s], mOwn[s+4]);
        end
        for (int j = 0; j < 4; j++) begin
            nChecks++;
            if (o0Log[a+j] !== trRow(0, 0, j) || o1Log[b+j] !== trRow(1, 0, j)) begin
                nFails++;
                $display("[TB] FAIL rstmid_row%0d: o0 %h o1 %h, need %h %h",
                         j, o0Log[a+j], o1Log[b+j], trRow(0, 0, j), trRow(1, 0, j));
            end
        end
    endtask

    initial begin
        $display("[TB] transposer_arbiter directed test start");
        test_reset();
        test_simultaneous();
        test_fairness();
        test_r0_only();
        test_input_stall();
        test_output_backpressure();
        test_tag_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
